// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: word width, parameter
// defaults, FSM state encoding and the halt-opcode decode helper.
package fetch_pkg;

  localparam int WORD_W = 32;
  localparam int OPCODE_W = 6;

  localparam logic [WORD_W-1:0]   DEFAULT_RESET_PC    = 32'h0000_0000;
  localparam logic [OPCODE_W-1:0] DEFAULT_HALT_OPCODE = 6'd63;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_e;

  function automatic logic is_halt(input logic [WORD_W-1:0] word,
                                   input logic [OPCODE_W-1:0] halt_opcode);
    return word[WORD_W-1 -: OPCODE_W] == halt_opcode;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word read at a time, presents the fetched
// word downstream, follows redirects and stops on the halt opcode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0]   RESET_PC    = DEFAULT_RESET_PC,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              imem_rvalid,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic [WORD_W-1:0] instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [WORD_W-1:0] pc_out,
  output logic              halted,
  output logic [WORD_W-1:0] fetch_count,
  output fetch_state_e      state_dbg
);

  // Handshake: a word transfers downstream on a rising edge where
  // instr_valid && instr_ready; while instr_valid=1 and no transfer happens,
  // instruction and pc_out hold. imem_req is a single-cycle strobe with no
  // ready; the response is the next imem_rvalid pulse, and a redirect during
  // an outstanding read turns that response into a discard.

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic              discard_q, discard_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pc_out_q, pc_out_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] count_q, count_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    valid_d   = valid_q;
    count_d   = count_q;
    imem_req  = 1'b0;
    imem_addr = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
        state_d   = ST_WAIT;
        // The read already left this cycle, so its response must be dropped.
        if (redirect_valid) begin
          pc_d      = redirect_pc;
          discard_d = 1'b1;
        end
      end

      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_rvalid) begin
            discard_d = 1'b0;
            state_d   = ST_REQ;
          end else begin
            discard_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = ST_REQ;
          end else begin
            instr_d  = imem_rdata;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + 1'b1;
            state_d  = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          state_d = ST_REQ;
        end else if (instr_ready) begin
          count_d = count_q + 1'b1;
          valid_d = 1'b0;
          state_d = is_halt(instr_q, HALT_OPCODE) ? ST_HALTED : ST_REQ;
        end
      end

      ST_HALTED: begin
        state_d = ST_HALTED;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      instr_q   <= '0;
      pc_out_q  <= '0;
      valid_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      instr_q   <= instr_d;
      pc_out_q  <= pc_out_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  assign instruction = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign fetch_count = count_q;
  assign halted      = (state_q == ST_HALTED);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus a randomized run checked
// against a program-order model of which word should be presented next.
module tb_fetch_unit;
  import fetch_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_rvalid = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc_out;
  logic        halted;
  logic [31:0] fetch_count;
  fetch_state_e state_dbg;

  fetch_unit dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_out(pc_out), .halted(halted), .fetch_count(fetch_count),
    .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // ---------------- memory model ----------------
  logic        halt_en = 1'b0;
  logic [31:0] halt_addr = 32'd5;
  int          lat = 1;
  bit          lat_rand = 1'b0;
  int          mem_cycle = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_due = 0;
  int          overlap_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (halt_en && a == halt_addr) return {6'd63, 26'd0};
    w = a * 32'h9E37_79B1 + 32'h0BAD_F00D;
    if (w[31:26] == 6'd63) w[31] = 1'b0;
    return w;
  endfunction

  // Responds mid-cycle so the response is seen at the next rising edge.
  always @(negedge clk) begin
    mem_cycle++;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pend && mem_cycle >= pend_due) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr);
      pend = 1'b0;
    end
    if (imem_req) begin
      if (pend) overlap_cnt++;
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_due  = mem_cycle + (lat_rand ? int'($urandom_range(1, 3)) : lat);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (instr_valid) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({imem_req, imem_addr, instruction, pc_out, instr_valid, halted, fetch_count} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: req=%b addr=%h instr=%h pc=%h v=%b h=%b cnt=%0d, all required 0",
               imem_req, imem_addr, instruction, pc_out, instr_valid, halted, fetch_count);
    end
    n_cmp++;
    if (state_dbg !== ST_IDLE) begin
      n_err++; $display("FAIL reset_state: got %0d required %0d", state_dbg, ST_IDLE);
    end
    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    n_cmp++;
    if (state_dbg !== ST_IDLE || imem_req !== 1'b0) begin
      n_err++; $display("FAIL reset_over_start: state=%0d req=%b required IDLE/0", state_dbg, imem_req);
    end
  endtask

  task automatic test_sequence();
    logic [31:0] exp_w, epc;
    int got, last;
    do_reset();
    lat = 1; lat_rand = 1'b0; instr_ready = 1'b1;
    exp_q = {};
    for (int k = 0; k < 3; k++) exp_q.push_back(mem_word(k));
    epc = 32'd0; got = 0; last = 0;
    do_start();
    for (int i = 0; i < 30 && got < 3; i++) begin
      if (instr_valid) begin
        exp_w = exp_q.pop_front();
        n_cmp++;
        if (instruction !== exp_w || pc_out !== epc) begin
          n_err++;
          $display("FAIL seq_word: got %h@%h required %h@%h", instruction, pc_out, exp_w, epc);
        end
        if (got > 0) begin
          n_cmp++;
          if (i - last != 3) begin
            n_err++; $display("FAIL seq_spacing: got %0d cycles required 3", i - last);
          end
        end
        last = i; epc++; got++;
      end
      tick();
    end
    instr_ready = 1'b0;
    n_cmp++;
    if (got != 3 || fetch_count !== 32'd3) begin
      n_err++; $display("FAIL seq_count: seen %0d count %0d required 3/3", got, fetch_count);
    end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset();
    lat = 1; instr_ready = 1'b0;
    do_start();
    wait_valid(10, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL stall_first_valid: got none required instr_valid within 10 cycles");
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (instr_valid !== 1'b1 || pc_out !== 32'd0 || instruction !== mem_word(0) ||
          imem_req !== 1'b0 || fetch_count !== 32'd0) begin
        n_err++;
        $display("FAIL stall_hold: v=%b pc=%h instr=%h req=%b cnt=%0d required 1/0/%h/0/0",
                 instr_valid, pc_out, instruction, imem_req, fetch_count, mem_word(0));
      end
      tick();
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_cmp++;
    if (fetch_count !== 32'd1 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_release: cnt=%0d v=%b required 1/0", fetch_count, instr_valid);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok, seen_req, stale;
    do_reset();
    lat = 3; instr_ready = 1'b1;
    do_start();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    seen_req = 1'b0; stale = 1'b0;
    for (int i = 0; i < 20 && !seen_req; i++) begin
      if (instr_valid) stale = 1'b1;
      if (imem_req) seen_req = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!seen_req || imem_addr !== 32'h40 || stale) begin
      n_err++;
      $display("FAIL redir_wait_req: seen=%b addr=%h stale_valid=%b required 1/00000040/0",
               seen_req, imem_addr, stale);
    end
    wait_valid(10, ok);
    n_cmp++;
    if (!ok || pc_out !== 32'h40 || instruction !== mem_word(32'h40)) begin
      n_err++;
      $display("FAIL redir_wait_word: ok=%b got %h@%h required %h@00000040",
               ok, instruction, pc_out, mem_word(32'h40));
    end
  endtask

  task automatic test_redirect_same();
    bit ok;
    do_reset();
    lat = 1; instr_ready = 1'b1;
    do_start();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL redir_same_req: req=%b addr=%h v=%b required 1/00000100/0",
               imem_req, imem_addr, instr_valid);
    end
    wait_valid(10, ok);
    n_cmp++;
    if (!ok || pc_out !== 32'h100 || instruction !== mem_word(32'h100)) begin
      n_err++;
      $display("FAIL redir_same_word: ok=%b got %h@%h required %h@00000100",
               ok, instruction, pc_out, mem_word(32'h100));
    end
  endtask

  task automatic test_halt();
    bit done;
    do_reset();
    halt_en = 1'b1; halt_addr = 32'd5; lat = 1; instr_ready = 1'b1;
    do_start();
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (halted) done = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!done || fetch_count !== 32'd6 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL halt_entry: halted=%b cnt=%0d v=%b required 1/6/0", done, fetch_count, instr_valid);
    end
    for (int i = 0; i < 10; i++) begin
      redirect_valid = 1'($urandom_range(0, 1));
      redirect_pc    = $urandom;
      start          = 1'($urandom_range(0, 1));
      tick();
      n_cmp++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b1 || fetch_count !== 32'd6) begin
        n_err++;
        $display("FAIL halt_stays: req=%b v=%b halted=%b cnt=%0d required 0/0/1/6",
                 imem_req, instr_valid, halted, fetch_count);
      end
    end
    do_reset();
    halt_en = 1'b0;
    n_cmp++;
    if (halted !== 1'b0 || state_dbg !== ST_IDLE) begin
      n_err++; $display("FAIL halt_reset: halted=%b state=%0d required 0/IDLE", halted, state_dbg);
    end
  endtask

  task automatic test_wrap_and_reset();
    bit ok, seen_req;
    do_reset();
    lat = 1; instr_ready = 1'b1;
    do_start();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    wait_valid(20, ok);
    n_cmp++;
    if (!ok || pc_out !== 32'hFFFF_FFFF || instruction !== mem_word(32'hFFFF_FFFF)) begin
      n_err++;
      $display("FAIL wrap_word: ok=%b got %h@%h required %h@ffffffff",
               ok, instruction, pc_out, mem_word(32'hFFFF_FFFF));
    end
    tick();
    seen_req = 1'b0;
    for (int i = 0; i < 10 && !seen_req; i++) begin
      if (imem_req) seen_req = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!seen_req || imem_addr !== 32'h0) begin
      n_err++; $display("FAIL wrap_addr: seen=%b addr=%h required 1/00000000", seen_req, imem_addr);
    end
    lat = 3;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({imem_req, imem_addr, instruction, pc_out, instr_valid, halted, fetch_count} !== '0 ||
        state_dbg !== ST_IDLE) begin
      n_err++;
      $display("FAIL midwait_reset: req=%b addr=%h instr=%h pc=%h v=%b h=%b cnt=%0d state=%0d required all 0/IDLE",
               imem_req, imem_addr, instruction, pc_out, instr_valid, halted, fetch_count, state_dbg);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b0 || state_dbg !== ST_IDLE) begin
        n_err++;
        $display("FAIL idle_ignores_rvalid: v=%b req=%b state=%0d required 0/0/IDLE",
                 instr_valid, imem_req, state_dbg);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] epc;
    int mcount;
    do_reset();
    lat_rand = 1'b1;
    do_start();
    epc = DEFAULT_RESET_PC; mcount = 0;
    for (int i = 0; i < 3000; i++) begin
      if (instr_valid) begin
        n_cmp++;
        if (pc_out !== epc || instruction !== mem_word(epc)) begin
          n_err++;
          $display("FAIL rand_word: cycle %0d got %h@%h required %h@%h",
                   i, instruction, pc_out, mem_word(epc), epc);
        end
      end
      n_cmp++;
      if (fetch_count !== 32'(mcount)) begin
        n_err++; $display("FAIL rand_count: cycle %0d got %0d required %0d", i, fetch_count, mcount);
      end
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      // Program order: a redirect replaces the next address and cancels any
      // acceptance; otherwise an accepted word advances to the following one.
      if (redirect_valid) epc = redirect_pc;
      else if (instr_valid && instr_ready) begin
        epc++;
        mcount++;
      end
      tick();
    end
    redirect_valid = 1'b0; instr_ready = 1'b0; lat_rand = 1'b0;
    n_cmp++;
    if (mcount < 100) begin
      n_err++; $display("FAIL rand_progress: got %0d accepted required at least 100", mcount);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_redirect_wait();
    test_redirect_same();
    test_halt();
    test_wrap_and_reset();
    test_random();
    n_cmp++;
    if (overlap_cnt != 0) begin
      n_err++; $display("FAIL outstanding: got %0d overlapping requests required 0", overlap_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the word address fetched first after start.
REQ-002 Parameter HALT_OPCODE, default 6'd63, is the instruction[31:26] value that stops fetch.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  leaves IDLE and begins fetching at pc.
REQ-006 imem_req  output  1  one-cycle instruction-memory read request.
REQ-007 imem_addr  output  32  word address of the request, valid while imem_req=1.
REQ-008 imem_rdata  input  32  read data, valid while imem_rvalid=1.
REQ-009 imem_rvalid  input  1  response strobe, at least 1 cycle after imem_req.
REQ-010 redirect_valid  input  1  taken branch/jump from control/ALU stage.
REQ-011 redirect_pc  input  32  absolute word target of the redirect.
REQ-012 instruction  output  32  fetched word presented to the control unit.
REQ-013 instr_valid  output  1  instruction/pc_out valid.
REQ-014 instr_ready  input  1  downstream accepts when instr_valid&&instr_ready.
REQ-015 pc_out  output  32  word address of the presented instruction.
REQ-016 halted  output  1  HALT_OPCODE was accepted downstream; fetch stopped.
REQ-017 fetch_count  output  32  count of instructions accepted downstream.

Function
REQ-018 FSM states: IDLE, REQ, WAIT, HOLD, HALTED.
REQ-019 IDLE: start=1 -> REQ; rvalid ignored.
REQ-020 REQ: imem_req=1, imem_addr=pc for exactly one cycle, then WAIT.
REQ-021 WAIT: rvalid=1 with no discard -> instruction<=imem_rdata, pc_out<=pc, instr_valid<=1, pc<=pc+1 (mod 2^32, 0xFFFF_FFFF wraps to 0), -> HOLD.
REQ-022 At most one outstanding request; imem_req never asserted in WAIT or HOLD.
REQ-023 HOLD: instruction, pc_out, instr_valid stable while instr_ready=0.
REQ-024 HOLD with instr_ready=1: fetch_count+1 (wraps); if instruction[31:26]==HALT_OPCODE -> HALTED, instr_valid<=0; else -> REQ, instr_valid<=0.
REQ-025 Fetch throughput: one instruction per 3 cycles at rvalid latency 1 and ready held high.
REQ-026 redirect_valid in REQ or HOLD: pc<=redirect_pc, instr_valid<=0, no count increment, -> REQ next cycle; the REQ-cycle request already issued is treated as in flight (discard set, -> WAIT).
REQ-027 redirect_valid in WAIT: pc<=redirect_pc, discard<=1, stay in WAIT; response arriving same cycle or later is dropped, discard<=0, -> REQ.
REQ-028 redirect wins over simultaneous rvalid or instr_ready; HALT not taken on that cycle.
REQ-029 redirect_valid in IDLE or HALTED ignored; start in HALTED ignored.
REQ-030 HALTED: imem_req=0, instr_valid=0, halted=1 until rst.

Reset
REQ-031 rst=1 at an edge: state<=IDLE, pc<=RESET_PC, discard<=0, imem_req=0, imem_addr=0, instruction=0, pc_out=0, instr_valid=0, halted=0, fetch_count=0.
REQ-032 rst overrides start, redirect, rvalid in the same cycle; responses arriving in IDLE after reset mid-WAIT are ignored.

Structure
REQ-033 Shared package fetch_pkg holds state enum, HALT_OPCODE and RESET_PC defaults, 32-bit word width constant.
REQ-034 No sub-module; single flat module with one registered FSM and datapath registers.

Verification
REQ-035 Reset, start, rvalid latency 1, ready high, mem[0..2]=A,B,C -> instr A@pc 0, B@1, C@2, 3 cycles apart, fetch_count=3.
REQ-036 Ready low 5 cycles while HOLD -> instruction/pc_out unchanged, no imem_req, count unchanged.
REQ-037 Redirect to 0x40 during WAIT, rvalid 2 cycles later with stale data -> stale word dropped, next imem_addr=0x40, instr_valid never shows stale word.
REQ-038 Redirect and rvalid same cycle -> response dropped, REQ at redirect_pc next cycle.
REQ-039 mem[5]={6'd63,26'd0}, accepted -> halted=1, no further imem_req, redirect/start ignored until rst.
REQ-040 pc=0xFFFF_FFFF fetch completes -> next imem_addr=0; rst asserted mid-WAIT -> all outputs at reset values next cycle.
